// File: rtl/mips_timer_if.sv
// Processor-bus slice seen by one timer device: bridge-decoded word address, byte enables, write data/strobe, read data.
// Latency: none of its own; read data follows the address combinationally inside the device.
// Backpressure: none; a strobed write always completes in the cycle it is presented.
interface mips_timer_if;
   logic [1:0]  Addr;
   logic [3:0]  BE;
   logic [31:0] DIn;
   logic        We;
   logic [31:0] DOut;

   // Bridge side: drives address/write controls, samples read data.
   modport master (output Addr, output BE, output DIn, output We, input DOut);
   // Device side: decodes address/write controls, returns read data.
   modport slave  (input Addr, input BE, input DIn, input We, output DOut);
endinterface

// File: rtl/mips_timer.sv
// Programmable down-counting bus timer (CTRL/PRESET/COUNT) with masked IRQ; optional prescaler via TIMER_PRESCALE_EN.
// Latency: reads combinational on Addr; IRQ registered, N+3 edges after Enable (N*PRESCALE+PRESCALE+2 with prescaler).
// Backpressure: none; every strobed write lands on the edge it is presented, COUNT writes are dropped.
module mips_timer #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        reset,
   mips_timer_if.slave bus,
   output logic        IRQ
);
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        enable;
   logic [1:0]  mode;
   logic        im;
   logic        pend;
   logic [31:0] preset;
   logic [31:0] count;
   logic [31:0] count_nxt;
   logic        tick;
   logic        ctrl_wr;
   logic        oneshot_done;

   // A CTRL write only means something when byte 0 is enabled; the upper bytes are not stored.
   assign ctrl_wr = bus.We && (bus.Addr == 2'd0) && bus.BE[0];

`ifdef TIMER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc;

   assign tick = (presc == PLAST);

   // Prescale counter: restarts on each load, wraps once per count step while counting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         presc <= '0;
      else if (state == LOAD)
         presc <= '0;
      else if ((state == CNT) && enable)
         presc <= tick ? '0 : presc + 1'b1;
   end
`else
   // Without the prescaler the counter steps on every cycle.
   assign tick = 1'b1;
`endif

   // Next-state and next-count decode; the zero check shares the decrement's tick.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      oneshot_done = 1'b0;
      case (state)
         IDLE: begin
            if (enable)
               state_nxt = LOAD;
         end
         LOAD: begin
            count_nxt = preset;
            state_nxt = CNT;
         end
         CNT: begin
            if (!enable)
               state_nxt = IDLE;
            else if (tick) begin
               if (count != '0)
                  count_nxt = count - 1'b1;
               else
                  state_nxt = INT;
            end
         end
         INT: begin
            if (mode == 2'b01)
               state_nxt = LOAD;
            else begin
               state_nxt    = IDLE;
               oneshot_done = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and count registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // CTRL and pending flag: a bus write to CTRL overrides the one-shot Enable clear and always clears pend.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable <= 1'b0;
         mode   <= 2'b00;
         im     <= 1'b0;
         pend   <= 1'b0;
      end else if (ctrl_wr) begin
         enable <= bus.DIn[0];
         mode   <= bus.DIn[2:1];
         im     <= bus.DIn[3];
         pend   <= 1'b0;
      end else if (oneshot_done) begin
         enable <= 1'b0;
         pend   <= 1'b1;
      end
   end

   // PRESET: byte-granular writes; a running count only sees it at the next load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         preset <= '0;
      else if (bus.We && (bus.Addr == 2'd1)) begin
         for (int i = 0; i < 4; i++)
            if (bus.BE[i])
               preset[8*i +: 8] <= bus.DIn[8*i +: 8];
      end
   end

   // Read mux: side-effect free, offset 3 reads as zero.
   always_comb begin
      bus.DOut = '0;
      case (bus.Addr)
         2'd0:    bus.DOut = {28'd0, im, mode, enable};
         2'd1:    bus.DOut = preset;
         2'd2:    bus.DOut = count;
         default: bus.DOut = '0;
      endcase
   end

   // IRQ from registered state only, so bus activity cannot glitch it.
   assign IRQ = im & ((state == INT) | pend);

endmodule

// File: tb/tb_mips_timer.sv
// Self-checking bench for mips_timer: directed scenarios plus randomized bus traffic against a timeline model.
// Latency: checks IRQ/DOut once per cycle at the falling edge, before the next rising edge.
// Backpressure: not applicable; the bench drives one bus access per cycle.
module tb_mips_timer;
   localparam int P =
`ifdef TIMER_PRESCALE_EN
      4;
`else
      1;
`endif

   logic clk;
   logic reset;
   logic irq;
   int   n_vec = 0;
   int   n_err = 0;

   mips_timer_if bus ();

   mips_timer #(.PRESCALE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .IRQ   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: register file plus a timeline (edge of the last load, edge at which INT is entered).
   logic        m_en, m_im, m_pend;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_count;
   bit          m_busy, m_int;
   longint      m_edge, m_load, m_intat, m_n;

   function automatic int per(input longint n);
      return int'((n + 1) * P + 2);
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_im, m_mode, m_en};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_irq();
      return m_im & (m_int | m_pend);
   endfunction

   task automatic m_reset();
      m_en = 0; m_im = 0; m_pend = 0; m_mode = 2'b00;
      m_preset = '0; m_count = '0;
      m_busy = 0; m_int = 0; m_load = 0; m_intat = 0; m_n = 0;
   endtask

   task automatic m_clock(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d, input logic we);
      bit clr_en = 0;
      bit set_pend = 0;
      longint e;
      m_edge++;
      e = m_edge;
      if (m_int) begin
         m_int = 0;
         if (m_mode == 2'b01)
            m_load = e + 1;
         else begin
            clr_en = 1; set_pend = 1; m_busy = 0;
         end
      end else if (!m_busy) begin
         if (m_en) begin
            m_busy = 1;
            m_load = e + 1;
         end
      end else if (e == m_load) begin
         m_n     = longint'(m_preset);
         m_count = m_preset;
         m_intat = e + (m_n + 1) * P;
      end else begin
         if (!m_en)
            m_busy = 0;
         else if (e == m_intat)
            m_int = 1;
         else
            m_count = 32'(m_n - (e - m_load) / P);
      end
      if (we && a == 2'd0 && be[0]) begin
         {m_im, m_mode, m_en} = d[3:0];
         m_pend = 0;
      end else begin
         if (clr_en) m_en = 0;
         if (set_pend) m_pend = 1;
      end
      if (we && a == 2'd1)
         for (int i = 0; i < 4; i++)
            if (be[i]) m_preset[8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One bus cycle: drive, check pre-edge outputs, clock, advance model, return at the falling edge.
   task automatic step(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d, input logic we);
      bus.Addr = a; bus.BE = be; bus.DIn = d; bus.We = we;
      #1;
      check_val("dout", bus.DOut, m_read(a));
      check_val("irq", {31'd0, irq}, {31'd0, m_irq()});
      @(posedge clk);
      m_clock(a, be, d, we);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'd2, 4'd0, 32'd0, 1'b0);
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
      bus.We = 1'b0; bus.Addr = a;
      #1;
      v = bus.DOut;
   endtask

   task automatic wait_irq(output int k);
      k = 0;
      do begin
         idle(1);
         k++;
      end while (irq !== 1'b1 && k < 400);
      if (irq !== 1'b1) check_val("irq_timeout", {31'd0, irq}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int k;
      int r;
      bus.Addr = 2'd0; bus.BE = 4'd0; bus.DIn = 32'd0; bus.We = 1'b0;
      reset = 1'b0;
      m_reset();
      m_edge = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int a = 0; a < 4; a++) step(2'(a), 4'd0, 32'd0, 1'b0);

      // Byte enables and read-only COUNT.
      step(2'd1, 4'hF, 32'd0, 1'b1);
      step(2'd1, 4'b0101, 32'hAABBCCDD, 1'b1);
      read_reg(2'd1, v); check_val("preset_be", v, 32'h00BB00DD);
      step(2'd2, 4'hF, 32'h12345678, 1'b1);
      read_reg(2'd2, v); check_val("count_ro", v, 32'd0);

      // One-shot, PRESET=5, IM=1: IRQ level held until a CTRL byte-0 write.
      step(2'd1, 4'hF, 32'd5, 1'b1);
      step(2'd0, 4'h1, 32'h9, 1'b1);
      wait_irq(k); check_val("oneshot_lat", 32'(k), 32'(per(5)));
      idle(2);
      read_reg(2'd2, v); check_val("oneshot_count", v, 32'd0);
      read_reg(2'd0, v); check_val("oneshot_ctrl", v, 32'h8);
      check_val("oneshot_hold", {31'd0, irq}, 32'd1);
      step(2'd0, 4'h1, 32'h8, 1'b1);
      check_val("oneshot_clear", {31'd0, irq}, 32'd0);

      // Auto-reload PRESET=3; a mid-count PRESET=10 write applies only after the next reload.
      step(2'd1, 4'hF, 32'd3, 1'b1);
      step(2'd0, 4'h1, 32'hB, 1'b1);
      wait_irq(k); check_val("reload_first", 32'(k), 32'(per(3)));
      wait_irq(k); check_val("reload_period", 32'(k), 32'(per(3)));
      idle(2);
      step(2'd1, 4'hF, 32'd10, 1'b1);
      wait_irq(k); check_val("reload_old", 32'(k), 32'(per(3) - 3));
      wait_irq(k); check_val("reload_new", 32'(k), 32'(per(10)));
      step(2'd0, 4'h1, 32'h0, 1'b1);
      idle(3);

      // Disable at COUNT=7 freezes; re-enable reloads from PRESET.
      step(2'd1, 4'hF, 32'd20, 1'b1);
      step(2'd0, 4'h1, 32'h9, 1'b1);
      for (int i = 0; i < 200; i++) begin
         read_reg(2'd2, v);
         if (v == ((P == 1) ? 32'd8 : 32'd7)) break;
         idle(1);
      end
      step(2'd0, 4'h1, 32'h8, 1'b1);
      idle(4);
      read_reg(2'd2, v); check_val("frozen_count", v, 32'd7);
      check_val("frozen_irq", {31'd0, irq}, 32'd0);
      step(2'd0, 4'h1, 32'h9, 1'b1);
      idle(2);
      read_reg(2'd2, v); check_val("reenable_reload", v, 32'd20);
      step(2'd0, 4'h1, 32'h0, 1'b1);
      idle(3);

      // IM=0 run; IM set on the edge INT is entered raises IRQ, pend then holds it.
      step(2'd1, 4'hF, 32'd1, 1'b1);
      step(2'd0, 4'h1, 32'h1, 1'b1);
      idle(per(1) - 1);
      check_val("masked_irq", {31'd0, irq}, 32'd0);
      step(2'd0, 4'h1, 32'h8, 1'b1);
      check_val("unmask_irq", {31'd0, irq}, 32'd1);
      idle(1);
      check_val("unmask_pend", {31'd0, irq}, 32'd1);
      step(2'd0, 4'h1, 32'h0, 1'b1);

      // PRESET=0 reaches INT quickly; a CTRL write leaving INT wins and clears pend.
      step(2'd1, 4'hF, 32'd0, 1'b1);
      step(2'd0, 4'h1, 32'h9, 1'b1);
      wait_irq(k); check_val("preset0_lat", 32'(k), 32'(per(0)));
      step(2'd0, 4'h1, 32'h9, 1'b1);
      check_val("collide_irq", {31'd0, irq}, 32'd0);
      read_reg(2'd0, v); check_val("collide_ctrl", v, 32'h9);
      step(2'd0, 4'h1, 32'h0, 1'b1);
      idle(3);

      // PRESET=FFFFFFFF counts down without wrapping.
      step(2'd1, 4'hF, 32'hFFFF_FFFF, 1'b1);
      step(2'd0, 4'h1, 32'h1, 1'b1);
      idle(2);
      read_reg(2'd2, v); check_val("max_load", v, 32'hFFFF_FFFF);
      idle(P);
      read_reg(2'd2, v); check_val("max_dec", v, 32'hFFFF_FFFE);
      step(2'd0, 4'h1, 32'h0, 1'b1);

      // Reset mid-count, asserted between edges.
      step(2'd1, 4'hF, 32'd9, 1'b1);
      step(2'd0, 4'h1, 32'hB, 1'b1);
      idle(5);
      #2 reset = 1'b0;
      #1 check_val("rst_irq", {31'd0, irq}, 32'd0);
      for (int a = 0; a < 4; a++) begin
         read_reg(2'(a), v); check_val("rst_read", v, 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      read_reg(2'd2, v); check_val("rst_static", v, 32'd0);
      reset = 1'b1;
      m_reset();
      idle(2);

      // Randomized bus traffic against the model.
      for (int i = 0; i < 2500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 65)
            step(2'($urandom), 4'($urandom), $urandom, 1'b0);
         else if (r < 78)
            step(2'd0, 4'($urandom), $urandom, 1'b1);
         else if (r < 90)
            step(2'd1, 4'($urandom), ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 8)), 1'b1);
         else
            step(2'($urandom_range(2, 3)), 4'($urandom), $urandom, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
